// File: rtl/counter_pkg.sv
// Shared helpers for the wrap counter: width sizing and Gray encoding.
package counter_pkg;

    // Reflected Gray code of a 32-bit binary value.
    function automatic logic [31:0] to_gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Bits needed to hold 0..max_value, never less than one.
    // Widened to 64 bits so max_value = 2^32-1 does not overflow on +1.
    function automatic int unsigned counter_width(input int unsigned max_value);
        longint unsigned span;
        int unsigned     w;
        span = longint'(max_value) + 64'd1;
        w    = $clog2(span);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/counter_wrap_gray_encoder.sv
// Combinational binary to Gray converter.
module gray_encoder
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = 3
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    logic [31:0] gray_full;

    // Encode at full package width, keeping only the live bits.
    always_comb begin
        gray_full = to_gray(32'(bin));
        gray      = gray_full[WIDTH-1:0];
    end

endmodule

// File: rtl/counter_wrap.sv
// Free-running up-counter with programmable step and wrap limit.
// Output is binary or Gray, chosen at elaboration.
module counter_wrap
    import counter_pkg::*;
#(
    parameter int unsigned MAX_VALUE = 7,
    parameter int unsigned INCREMENT = 1,
    parameter int unsigned GRAY      = 0
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 enable,
    output logic [counter_width(MAX_VALUE)-1:0]  count
);

    localparam int unsigned WIDTH = counter_width(MAX_VALUE);

    if (INCREMENT < 1) begin : g_bad_inc_low
        $error("counter_wrap: INCREMENT must be at least 1");
    end
    if (INCREMENT > MAX_VALUE) begin : g_bad_inc_high
        $error("counter_wrap: INCREMENT must not exceed MAX_VALUE");
    end
    if (GRAY > 1) begin : g_bad_gray
        $error("counter_wrap: GRAY must be 0 or 1");
    end

    logic [WIDTH-1:0] bin;
    logic [WIDTH-1:0] next_bin;
    logic [WIDTH-1:0] next_count;
    logic [WIDTH-1:0] bin_plus;
    logic [32:0]      wide_sum;
    logic             wrap;

    // Overflow test runs at 33 bits; the stored sum is lossless at WIDTH
    // because a non-wrapping result never exceeds MAX_VALUE.
    always_comb begin
        wide_sum = 33'(bin) + 33'(INCREMENT);
        wrap     = (wide_sum > 33'(MAX_VALUE));
        bin_plus = bin + WIDTH'(INCREMENT);
        next_bin = bin;
        if (enable) begin
            next_bin = wrap ? '0 : bin_plus;
        end
    end

    if (GRAY == 1) begin : g_gray
        gray_encoder #(.WIDTH(WIDTH)) u_gray_encoder (
            .bin  (next_bin),
            .gray (next_count)
        );
    end else begin : g_bin
        assign next_count = next_bin;
    end

    // Binary state and encoded output update on the same edge; output is
    // taken from next_bin so it is never decoded from the bin flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            bin   <= '0;
            count <= '0;
        end else begin
            bin   <= next_bin;
            count <= next_count;
        end
    end

endmodule

// File: tb/tb_counter_wrap.sv
// Directed self-checking bench for counter_wrap in four configurations.
module tb_counter_wrap;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [2:0] cnt_bin;
    logic [2:0] cnt_gray;
    logic [5:0] cnt_addr;
    logic [3:0] cnt_na;

    int unsigned checks = 0;
    int unsigned errors = 0;

    int unsigned exp_bin  [9] = '{1, 2, 3, 4, 5, 6, 7, 0, 1};
    int unsigned exp_gray [9] = '{1, 3, 2, 6, 7, 5, 4, 0, 1};
    int unsigned exp_addr [9] = '{8, 16, 24, 32, 40, 48, 56, 0, 8};
    int unsigned exp_na   [9] = '{3, 6, 9, 0, 3, 6, 9, 0, 3};
    int unsigned gate_en  [4] = '{1, 0, 0, 1};
    int unsigned gate_exp [4] = '{1, 1, 1, 2};

    always #5 clk = ~clk;

    counter_wrap #(.MAX_VALUE(7), .INCREMENT(1), .GRAY(0)) u_bin (
        .clk(clk), .reset(reset), .enable(enable), .count(cnt_bin)
    );
    counter_wrap #(.MAX_VALUE(7), .INCREMENT(1), .GRAY(1)) u_gray (
        .clk(clk), .reset(reset), .enable(enable), .count(cnt_gray)
    );
    counter_wrap #(.MAX_VALUE(56), .INCREMENT(8), .GRAY(0)) u_addr (
        .clk(clk), .reset(reset), .enable(enable), .count(cnt_addr)
    );
    counter_wrap #(.MAX_VALUE(10), .INCREMENT(3), .GRAY(0)) u_na (
        .clk(clk), .reset(reset), .enable(enable), .count(cnt_na)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] prev_gray;

        reset  = 1'b1;
        enable = 1'b0;
        tick();
        tick();
        check("reset_bin",  32'(cnt_bin),  0);
        check("reset_gray", 32'(cnt_gray), 0);
        check("reset_addr", 32'(cnt_addr), 0);
        check("reset_na",   32'(cnt_na),   0);

        // Nine enabled cycles: wrap behaviour for every configuration.
        reset     = 1'b0;
        enable    = 1'b1;
        prev_gray = 3'd0;
        for (int i = 0; i < 9; i++) begin
            tick();
            check($sformatf("bin_seq[%0d]", i),  32'(cnt_bin),  exp_bin[i]);
            check($sformatf("gray_seq[%0d]", i), 32'(cnt_gray), exp_gray[i]);
            check($sformatf("gray_onebit[%0d]", i), 32'($countones(cnt_gray ^ prev_gray)), 1);
            check($sformatf("addr_seq[%0d]", i), 32'(cnt_addr), exp_addr[i]);
            check($sformatf("na_seq[%0d]", i),   32'(cnt_na),   exp_na[i]);
            prev_gray = cnt_gray;
        end

        // Enable gating from a fresh reset.
        reset  = 1'b1;
        enable = 1'b0;
        tick();
        check("gate_reset", 32'(cnt_bin), 0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            enable = gate_en[i][0];
            tick();
            check($sformatf("gate[%0d]", i), 32'(cnt_bin), gate_exp[i]);
        end

        // Advance binary counter to 5 (gray of 5 is 7).
        enable = 1'b1;
        tick();
        tick();
        tick();
        check("pre_reset_bin",  32'(cnt_bin),  5);
        check("pre_reset_gray", 32'(cnt_gray), 7);

        // Reset wins over enable and holds zero throughout.
        reset = 1'b1;
        tick();
        check("mid_reset_bin0",  32'(cnt_bin),  0);
        check("mid_reset_gray0", 32'(cnt_gray), 0);
        tick();
        check("mid_reset_bin1",  32'(cnt_bin),  0);
        check("mid_reset_gray1", 32'(cnt_gray), 0);

        reset = 1'b0;
        tick();
        check("post_reset_bin",  32'(cnt_bin),  1);
        check("post_reset_gray", 32'(cnt_gray), 1);
        check("post_reset_addr", 32'(cnt_addr), 8);
        check("post_reset_na",   32'(cnt_na),   3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/counter_wrap.md
Name: counter_wrap

Overview:
- Parameterised free-running up-counter with programmable step and wrap limit. Output is encoded as plain binary or reflected Gray code, selected by parameter.
- One block provides both counter flavours used by the async FIFO:
  - Gray-coded read/write pointers, safe for clock-domain crossing.
  - Binary memory-address counters that step by DATA_WIDTH.
- Fully synchronous, single clock. The count output is registered, so it has no combinational glitches.

Parameters:
- MAX_VALUE, default 7: largest binary value the internal count may hold; 32-bit unsigned, must be ≥ 1.
- INCREMENT, default 1: step added per enabled cycle; 32-bit unsigned, 1 ≤ INCREMENT ≤ MAX_VALUE.
- GRAY, default 0: 0 = count output is binary; 1 = count output is Gray encoding of the internal binary count.
- WIDTH (localparam): $clog2(MAX_VALUE+1), minimum 1; width of count.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  advance the count this cycle.
- count  output  WIDTH  registered count (binary, or Gray when GRAY=1).

Behaviour:
- Internal register bin[WIDTH-1:0] holds the binary count. Output register count is updated in the same clock edge as bin.
- Reset:
  - Reset is sampled on the rising clock edge only; this is the already-decided single clock with synchronous, active-high reset.
  - On reset, bin = 0 and count = 0. This holds for both encodings, since Gray(0) = 0.
  - Reset has priority over enable.
  - Reset asserted mid-count returns count to 0 on the next edge.
- Enable:
  - enable = 0: bin and count hold.
  - enable = 1 with bin + INCREMENT ≤ MAX_VALUE: bin ← bin + INCREMENT.
  - enable = 1 with bin + INCREMENT > MAX_VALUE: bin ← 0. The wrap always returns to zero; there is no modulo remainder.
- Arithmetic width:
  - The comparison bin + INCREMENT > MAX_VALUE is evaluated at 33-bit (or wider) precision so it never overflows.
  - The stored result is truncated to WIDTH bits, which is lossless by construction.
- Latency: count reflects an enable on the following rising edge (1 cycle).
- Gray mode:
  - count ← next_bin ^ (next_bin >> 1), registered. count is never derived combinationally from the bin flop outputs.
  - With INCREMENT = 1 and MAX_VALUE+1 a power of two, consecutive values, including the wrap, differ by exactly one bit.
  - Other configurations are legal, but the single-bit-change property is not guaranteed for them.
- Binary mode: count ← next_bin.
- enable is treated as a synchronous level input; it has no effect during reset.
- No X propagation after reset: all flops are reset.

Decomposition:
- Package counter_pkg:
  - function to_gray(logic [31:0]) → logic [31:0].
  - function counter_width(int unsigned max_value) → int unsigned, returning max(1, $clog2(max_value+1)).
- One optional sub-module: gray_encoder, combinational with parameter WIDTH and ports bin → gray. It is instantiated only when GRAY=1 (generate); otherwise next_bin passes through unchanged.
- Parameter legality checks: elaboration-time assertions for INCREMENT ≥ 1, INCREMENT ≤ MAX_VALUE, and GRAY ∈ {0,1}.

Test Plan:
- Binary wrap: MAX_VALUE=7, INCREMENT=1, GRAY=0; enable high 9 cycles after reset → count 1,2,3,4,5,6,7,0,1.
- Gray sequence: MAX_VALUE=7, INCREMENT=1, GRAY=1; enable high 9 cycles → count 1,3,2,6,7,5,4,0,1. Check exactly one bit changes per step.
- Address stepping: MAX_VALUE=56, INCREMENT=8, GRAY=0 (WIDTH=6); enable high → 8,16,…,56,0.
- Non-aligned step: MAX_VALUE=10, INCREMENT=3 → 3,6,9,0,3. The wrap goes to 0, not 2.
- Enable gating: toggle enable 1,0,0,1 from reset (MAX_VALUE=7, binary) → count 1,1,1,2. Count holds while enable=0.
- Reset mid-operation: count at 5, assert reset for 1 cycle with enable=1 → count 0 next edge. Release reset → 1 on the following enabled edge. Verify count=0 throughout reset for both GRAY settings.
